wb_bus_arbiter: RTL and testbench

//  Grants one pipelined Wishbone B4 master port to two requesters: s1 (instruction fetch) and s2 (load/store).

---
 rtl/ecap5_dproc_pkg.sv | 11 +
 rtl/wb_bus_arbiter.sv | 98 +++++++++
 tb/tb_wb_bus_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared arbiter state type and owner selection helper
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT1, ARB_GRANT2, ARB_DRAIN} arb_state_t;

    // s2 wins a tie unless s1 has starved
    function automatic arb_state_t arb_pick(input logic c1, input logic c2, input logic starve);
        return (c1 && (starve || !c2)) ? ARB_GRANT1 : c2 ? ARB_GRANT2 : ARB_IDLE;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one pipelined Wishbone master port between fetch (s1) and load/store (s2)
module wb_bus_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int STARVE_LIMIT    = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s1_wb_adr_i,
    input  logic [31:0] s1_wb_dat_i,
    input  logic [3:0]  s1_wb_sel_i,
    input  logic        s1_wb_we_i,
    input  logic        s1_wb_stb_i,
    input  logic        s1_wb_cyc_i,
    output logic [31:0] s1_wb_dat_o,
    output logic        s1_wb_ack_o,
    output logic        s1_wb_stall_o,
    input  logic [31:0] s2_wb_adr_i,
    input  logic [31:0] s2_wb_dat_i,
    input  logic [3:0]  s2_wb_sel_i,
    input  logic        s2_wb_we_i,
    input  logic        s2_wb_stb_i,
    input  logic        s2_wb_cyc_i,
    output logic [31:0] s2_wb_dat_o,
    output logic        s2_wb_ack_o,
    output logic        s2_wb_stall_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_cyc_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_stall_i,
    output logic [1:0]  grant_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state, state_next, pick;
    logic [OW-1:0] outstanding, outstanding_next;
    logic [WW-1:0] s1_wait;
    logic          own1, route2, at_max, starve, idle_bus, ack_ok, accept, drop;

    always_comb begin
        own1   = state == ARB_GRANT1;
        route2 = state == ARB_GRANT2 || state == ARB_DRAIN;
        at_max = outstanding == OW'(MAX_OUTSTANDING);
        starve = s1_wait >= WW'(STARVE_LIMIT);
        idle_bus = outstanding == '0;
        ack_ok = m_wb_ack_i && !idle_bus;
        m_wb_cyc_o = own1 ? s1_wb_cyc_i : state == ARB_GRANT2 ? s2_wb_cyc_i : state == ARB_DRAIN;
        m_wb_stb_o = !at_max && (own1 ? s1_wb_stb_i : state == ARB_GRANT2 && s2_wb_stb_i);
        m_wb_adr_o = own1 ? s1_wb_adr_i : route2 ? s2_wb_adr_i : '0;
        m_wb_dat_o = own1 ? s1_wb_dat_i : route2 ? s2_wb_dat_i : '0;
        m_wb_sel_o = own1 ? s1_wb_sel_i : route2 ? s2_wb_sel_i : '0;
        m_wb_we_o  = own1 ? s1_wb_we_i : route2 && s2_wb_we_i;
        s1_wb_dat_o   = own1 ? m_wb_dat_i : '0;
        s2_wb_dat_o   = route2 ? m_wb_dat_i : '0;
        s1_wb_ack_o   = own1 && ack_ok;
        s2_wb_ack_o   = route2 && ack_ok;
        s1_wb_stall_o = !own1 || m_wb_stall_i || at_max;
        s2_wb_stall_o = state != ARB_GRANT2 || m_wb_stall_i || at_max;
        grant_o = {route2, own1};
        accept = m_wb_stb_o && !m_wb_stall_i;
        // owner abandoning its cycle forfeits any acks still in flight
        drop = ((own1 && !s1_wb_cyc_i) || (state == ARB_GRANT2 && !s2_wb_cyc_i)) && !idle_bus;
        outstanding_next = drop ? '0 :
                           (accept && !ack_ok) ? outstanding + 1'b1 :
                           (ack_ok && !accept) ? outstanding - 1'b1 : outstanding;
        pick = arb_pick(s1_wb_cyc_i, s2_wb_cyc_i, starve);
        state_next = state;
        case (state)
            ARB_IDLE:   state_next = pick;
            ARB_GRANT1: state_next = s1_wb_cyc_i ? ARB_GRANT1 : idle_bus ? pick : ARB_IDLE;
            ARB_GRANT2: state_next = !s2_wb_cyc_i ? (idle_bus ? pick : ARB_IDLE) :
                                     starve ? ARB_DRAIN : ARB_GRANT2;
            ARB_DRAIN:  state_next = idle_bus ? arb_pick(s1_wb_cyc_i, s2_wb_cyc_i, 1'b1) : ARB_DRAIN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ARB_IDLE;
            outstanding <= '0;
            s1_wait     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            s1_wait     <= (!s1_wb_cyc_i || state_next == ARB_GRANT1) ? '0 :
                           (state != ARB_GRANT1 && !starve) ? s1_wait + 1'b1 : s1_wait;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed cycle vectors for the two-requester Wishbone arbiter
module tb_wb_bus_arbiter;

    localparam logic [31:0] RD  = 32'hDEADBEEF;
    localparam logic [31:0] S1A = 32'h0000_0100;
    localparam logic [31:0] S2A = 32'h0000_0200;
    localparam logic [31:0] S1D = 32'h1111_1111;
    localparam logic [31:0] S2D = 32'h2222_2222;
    localparam logic [7:0]  IDLE_EX = 8'b00_0_0_0_1_0_1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s1_wb_adr_i, s1_wb_dat_i, s2_wb_adr_i, s2_wb_dat_i;
    logic [3:0]  s1_wb_sel_i, s2_wb_sel_i;
    logic        s1_wb_we_i, s1_wb_stb_i, s1_wb_cyc_i;
    logic        s2_wb_we_i, s2_wb_stb_i, s2_wb_cyc_i;
    logic [31:0] s1_wb_dat_o, s2_wb_dat_o;
    logic        s1_wb_ack_o, s1_wb_stall_o, s2_wb_ack_o, s2_wb_stall_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_stb_o, m_wb_cyc_o, m_wb_ack_i, m_wb_stall_i;
    logic [1:0]  grant_o;

    assign s1_wb_adr_i = S1A;
    assign s1_wb_dat_i = S1D;
    assign s1_wb_sel_i = 4'h3;
    assign s1_wb_we_i  = 1'b0;
    assign s2_wb_adr_i = S2A;
    assign s2_wb_dat_i = S2D;
    assign s2_wb_sel_i = 4'hC;
    assign s2_wb_we_i  = 1'b1;
    assign m_wb_dat_i  = RD;

    always #5 clk_i = ~clk_i;

    wb_bus_arbiter #(.STARVE_LIMIT(8), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s1_wb_adr_i(s1_wb_adr_i), .s1_wb_dat_i(s1_wb_dat_i), .s1_wb_sel_i(s1_wb_sel_i),
        .s1_wb_we_i(s1_wb_we_i), .s1_wb_stb_i(s1_wb_stb_i), .s1_wb_cyc_i(s1_wb_cyc_i),
        .s1_wb_dat_o(s1_wb_dat_o), .s1_wb_ack_o(s1_wb_ack_o), .s1_wb_stall_o(s1_wb_stall_o),
        .s2_wb_adr_i(s2_wb_adr_i), .s2_wb_dat_i(s2_wb_dat_i), .s2_wb_sel_i(s2_wb_sel_i),
        .s2_wb_we_i(s2_wb_we_i), .s2_wb_stb_i(s2_wb_stb_i), .s2_wb_cyc_i(s2_wb_cyc_i),
        .s2_wb_dat_o(s2_wb_dat_o), .s2_wb_ack_o(s2_wb_ack_o), .s2_wb_stall_o(s2_wb_stall_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
        .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cyc_o(m_wb_cyc_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_stall_i(m_wb_stall_i),
        .grant_o(grant_o)
    );

    // in = {s1 cyc, s1 stb, s2 cyc, s2 stb, slave ack, slave stall}
    // ex = {grant[1:0], m cyc, m stb, s1 ack, s1 stall, s2 ack, s2 stall}
    typedef struct {
        string      nm;
        logic [5:0] in;
        logic [7:0] ex;
    } vec_t;

    vec_t tbl[31];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic drive(input logic [5:0] in);
        {s1_wb_cyc_i, s1_wb_stb_i, s2_wb_cyc_i, s2_wb_stb_i, m_wb_ack_i, m_wb_stall_i} = in;
    endtask

    // routed fields follow the grant: s1 fields under 01, s2 fields under 10, zero otherwise
    task automatic check(input string nm, input logic [7:0] ex);
        logic [1:0]   g;
        logic [140:0] act, exp;
        g   = ex[7:6];
        act = {grant_o, m_wb_cyc_o, m_wb_stb_o, s1_wb_ack_o, s1_wb_stall_o, s2_wb_ack_o, s2_wb_stall_o,
               m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, s1_wb_dat_o, s2_wb_dat_o};
        exp = {ex,
               g == 2'b01 ? S1A : g == 2'b10 ? S2A : 32'h0,
               g == 2'b01 ? S1D : g == 2'b10 ? S2D : 32'h0,
               g == 2'b01 ? 4'h3 : g == 2'b10 ? 4'hC : 4'h0,
               g == 2'b10,
               g == 2'b01 ? RD : 32'h0,
               g == 2'b10 ? RD : 32'h0};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [5:0] in, input logic [7:0] ex);
        @(negedge clk_i);
        drive(in);
        #1;
        check(nm, ex);
    endtask

    initial begin
        tbl = '{
            '{"s1_req_idle",       6'b11_00_0_0, IDLE_EX},
            '{"s1_grant_stb",      6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"s1_wait_ack",       6'b10_00_0_0, 8'b01_1_0_0_0_0_1},
            '{"s1_ack",            6'b10_00_1_0, 8'b01_1_0_1_0_0_1},
            '{"s1_release",        6'b00_00_0_0, 8'b01_0_0_0_0_0_1},
            '{"idle_after_s1",     6'b00_00_0_0, IDLE_EX},
            '{"both_req_idle",     6'b11_11_0_0, IDLE_EX},
            '{"s2_wins",           6'b11_11_0_0, 8'b10_1_1_0_1_0_0},
            '{"s2_ack",            6'b11_10_1_0, 8'b10_1_0_0_1_1_0},
            '{"s2_release",        6'b11_00_0_0, 8'b10_0_0_0_1_0_0},
            '{"s1_after_s2",       6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"s1_ack2",           6'b10_00_1_0, 8'b01_1_0_1_0_0_1},
            '{"s1_accept",         6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"ack_and_accept",    6'b11_00_1_0, 8'b01_1_1_1_0_0_1},
            '{"last_ack",          6'b10_00_1_0, 8'b01_1_0_1_0_0_1},
            '{"extra_ack_dropped", 6'b10_00_1_0, 8'b01_1_0_0_0_0_1},
            '{"s1_release2",       6'b00_00_0_0, 8'b01_0_0_0_0_0_1},
            '{"idle_spurious_ack", 6'b00_00_1_0, IDLE_EX},
            '{"s1_req3",           6'b11_00_0_0, IDLE_EX},
            '{"slave_stall",       6'b11_00_0_1, 8'b01_1_1_0_1_0_1},
            '{"accept1",           6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"accept2",           6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"accept3",           6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"accept4",           6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"at_max5",           6'b11_00_0_0, 8'b01_1_0_0_1_0_1},
            '{"at_max6",           6'b11_00_0_0, 8'b01_1_0_0_1_0_1},
            '{"max_ack",           6'b11_00_1_0, 8'b01_1_0_1_1_0_1},
            '{"refill",            6'b11_00_0_0, 8'b01_1_1_0_0_0_1},
            '{"max_again",         6'b11_00_0_0, 8'b01_1_0_0_1_0_1},
            '{"drop_with_pending", 6'b00_00_0_0, 8'b01_0_0_0_1_0_1},
            '{"stale_ack_idle",    6'b00_00_1_0, IDLE_EX}
        };
        drive(6'b0);
        @(negedge clk_i);
        #1;
        check("reset", IDLE_EX);
        rst_i = 1'b0;
        for (int i = 0; i < 31; i++) cyc(tbl[i].nm, tbl[i].in, tbl[i].ex);
        // starvation: s2 keeps cyc while s1 waits, then drains two pending acks
        cyc("s2_req",        6'b00_11_0_0, IDLE_EX);
        cyc("s2_grant",      6'b00_11_0_0, 8'b10_1_1_0_1_0_0);
        cyc("s2_stb_s1_req", 6'b11_11_0_0, 8'b10_1_1_0_1_0_0);
        for (int i = 1; i < 8; i++) cyc("s1_starving", 6'b11_10_0_0, 8'b10_1_0_0_1_0_0);
        cyc("starve_limit",     6'b11_10_0_0, 8'b10_1_0_0_1_0_0);
        cyc("drain_stb_masked", 6'b11_11_0_0, 8'b10_1_0_0_1_0_1);
        cyc("drain_ack1",       6'b11_11_1_0, 8'b10_1_0_0_1_1_1);
        cyc("drain_hold",       6'b11_11_0_0, 8'b10_1_0_0_1_0_1);
        cyc("drain_ack2",       6'b11_11_1_0, 8'b10_1_0_0_1_1_1);
        cyc("drain_done",       6'b11_11_0_0, 8'b10_1_0_0_1_0_1);
        cyc("s1_after_drain",   6'b11_11_0_0, 8'b01_1_1_0_0_0_1);
        cyc("s1_ack3",          6'b10_11_1_0, 8'b01_1_0_1_0_0_1);
        cyc("s1_release3",      6'b00_11_0_0, 8'b01_0_0_0_0_0_1);
        for (int i = 0; i < 3; i++) cyc("s2_fill", 6'b00_11_0_0, 8'b10_1_1_0_1_0_0);
        // reset with three requests in flight, then late acks must vanish
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(6'b00_11_1_0);
        #1;
        check("rst_mid", IDLE_EX);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(6'b00_00_1_0);
        #1;
        check("post_rst_ack", IDLE_EX);
        cyc("post_rst_req",   6'b00_11_1_0, IDLE_EX);
        cyc("post_rst_grant", 6'b00_11_1_0, 8'b10_1_1_0_1_0_0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
